membus_io_ctrl: RTL and testbench

- Parametrised sequencer between the Core memory port and the bidirectional data-bus pads and address/write-enable output pads of the pad ring.
- Replaces direct core-to-pad wiring of the memory bus with a valid/ready request channel and registered pad outputs.
- Provides a programmable write hold, bus turnaround dead cycles and read-sample latency.
- Generalises the fixed 16-bit data / 8-bit address bus to any width.

---
 rtl/membus_pkg.sv | 19 +
 rtl/membus_dly_cnt.sv | 28 ++
 rtl/membus_io_ctrl.sv | 141 ++++++++++++++
 tb/tb_membus_io_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/membus_pkg.sv
// Shared definitions for the core-to-pad memory bus sequencer: FSM state codes,
// default bus widths and the even-parity helper.
package membus_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;
    localparam int PAR_MAX_W  = 1024;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] TURN  = 2'd3;

    // Zero extension leaves the XOR-reduce unchanged, so callers pass any width up to PAR_MAX_W.
    function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/membus_dly_cnt.sv
// Loadable down-counter with zero flag; shared by write-hold, read-latency and turnaround delays.
// Load has priority over decrement; decrement saturates at zero.
module membus_dly_cnt #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/membus_io_ctrl.sv
// Sequences valid/ready memory requests onto registered address/data/OE pads with write hold,
// turnaround dead cycles and read-sample latency; req_ready only in IDLE.
// Optional pad parity via MEMBUS_PARITY_EN.
module membus_io_ctrl
    import membus_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int RD_LATENCY  = 1,
    parameter int WR_HOLD     = 1,
    parameter int TURN_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef MEMBUS_PARITY_EN
    output logic              pad_par_out,
    input  logic              pad_par_in,
    output logic              rsp_par_err,
`endif
    output logic [ADDR_W-1:0] pad_addr,
    output logic [DATA_W-1:0] pad_dout,
    input  logic [DATA_W-1:0] pad_din,
    output logic              pad_oe
);

    localparam int MAX_RW  = (RD_LATENCY > WR_HOLD) ? RD_LATENCY : WR_HOLD;
    localparam int MAX_DLY = (MAX_RW > TURN_CYCLES) ? MAX_RW : TURN_CYCLES;
    localparam int CNT_W   = (MAX_DLY > 0) ? $clog2(MAX_DLY + 1) : 1;

    localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_HOLD - 1);
    localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             accept;
    logic             capture;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign capture   = (state == READ) && cnt_zero;

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_load  = 1'b1;
                    state_nxt = req_we ? WRITE : READ;
                    cnt_val   = req_we ? WR_LOAD : RD_LOAD;
                end
            end
            WRITE: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (TURN_CYCLES > 0) begin
                    state_nxt = TURN;
                    cnt_load  = 1'b1;
                    cnt_val   = TURN_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            READ, TURN: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    membus_dly_cnt #(
        .CNT_W (CNT_W)
    ) u_dly_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // pad_oe registers the next-state decode so it is high exactly in WRITE cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pad_oe    <= 1'b0;
            pad_addr  <= '0;
            pad_dout  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            pad_oe    <= (state_nxt == WRITE);
            rsp_valid <= capture;
            if (accept) begin
                pad_addr <= req_addr;
            end
            if (accept && req_we) begin
                pad_dout <= req_wdata;
            end
            if (capture) begin
                rsp_rdata <= pad_din;
            end
        end
    end

`ifdef MEMBUS_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_par_out <= 1'b0;
            rsp_par_err <= 1'b0;
        end else begin
            if (accept && req_we) begin
                pad_par_out <= even_par(PAR_MAX_W'(req_wdata));
            end
            if (capture) begin
                rsp_par_err <= even_par(PAR_MAX_W'(pad_din)) ^ pad_par_in;
            end
        end
    end
`endif

endmodule

// File: tb/tb_membus_io_ctrl.sv
// Self-checking bench for membus_io_ctrl with a pad-side memory model and a request-level scoreboard.
module tb_membus_io_ctrl;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 8;
    localparam int RD_LATENCY  = 2;
    localparam int WR_HOLD     = 1;
    localparam int TURN_CYCLES = 1;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] pad_addr;
    logic [DATA_W-1:0] pad_dout;
    logic [DATA_W-1:0] pad_din;
    logic              pad_oe;
`ifdef MEMBUS_PARITY_EN
    logic              pad_par_out;
    logic              pad_par_in;
    logic              rsp_par_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] pad_mem [0:255];
    logic [DATA_W-1:0] ref_mem [0:255];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_a  = '0;
    logic [DATA_W-1:0] pl_d  = '0;
    logic              ovr_en  = 1'b0;
    logic [DATA_W-1:0] ovr_din = '0;
    logic              ovr_par = 1'b0;

    membus_io_ctrl #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .RD_LATENCY  (RD_LATENCY),
        .WR_HOLD     (WR_HOLD),
        .TURN_CYCLES (TURN_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
`ifdef MEMBUS_PARITY_EN
        .pad_par_out (pad_par_out),
        .pad_par_in  (pad_par_in),
        .rsp_par_err (rsp_par_err),
`endif
        .pad_addr    (pad_addr),
        .pad_dout    (pad_dout),
        .pad_din     (pad_din),
        .pad_oe      (pad_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External memory behind the pads: latches data on write-enable, drives DataIn from the address pads.
    always @(posedge clk) begin
        if (pl_en) pad_mem[pl_a] <= pl_d;
        else if (pad_oe) pad_mem[pad_addr] <= pad_dout;
    end
    assign pad_din = ovr_en ? ovr_din : pad_mem[pad_addr];
`ifdef MEMBUS_PARITY_EN
    assign pad_par_in = ovr_en ? ovr_par : ^pad_din;
`endif

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pl_a = a; pl_d = d; pl_en = 1'b1; ref_mem[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic present(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: req_ready=%b required 1 within 20 cycles", req_ready);
        end
    endtask

    // Call at a negedge where the write is presented and req_ready=1; returns at the negedge where req_ready is 1 again.
    task automatic write_phase(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input bit hold_rd, input logic [ADDR_W-1:0] rd_a);
        ref_mem[a] = d;
        for (int j = 1; j <= WR_HOLD; j++) begin
            @(negedge clk);
            checks++; if (pad_oe !== 1'b1) begin errors++; $display("FAIL wr_oe cyc%0d: got %b need 1", j, pad_oe); end
            checks++; if (pad_addr !== a) begin errors++; $display("FAIL wr_addr cyc%0d: got %h need %h", j, pad_addr, a); end
            checks++; if (pad_dout !== d) begin errors++; $display("FAIL wr_dout cyc%0d: got %h need %h", j, pad_dout, d); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wr_ready cyc%0d: got %b need 0", j, req_ready); end
`ifdef MEMBUS_PARITY_EN
            checks++; if (pad_par_out !== ^d) begin errors++; $display("FAIL wr_par cyc%0d: got %b need %b", j, pad_par_out, ^d); end
`endif
            if (j == 1) begin
                if (hold_rd) begin req_we = 1'b0; req_addr = rd_a; end
                else req_valid = 1'b0;
            end
        end
        for (int j = 1; j <= TURN_CYCLES; j++) begin
            @(negedge clk);
            checks++; if (pad_oe !== 1'b0) begin errors++; $display("FAIL turn_oe cyc%0d: got %b need 0", j, pad_oe); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL turn_ready cyc%0d: got %b need 0", j, req_ready); end
        end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_done_ready: got %b need 1", req_ready); end
        checks++; if (pad_oe !== 1'b0) begin errors++; $display("FAIL wr_done_oe: got %b need 0", pad_oe); end
    endtask

    // Call at a negedge where the read is presented and req_ready=1; returns at the rsp_valid negedge.
    task automatic read_phase(input logic [DATA_W-1:0] exp);
        logic exp_err;
        exp_err = 1'b0;
        for (int j = 1; j <= RD_LATENCY; j++) begin
            @(negedge clk);
            checks++; if (pad_oe !== 1'b0) begin errors++; $display("FAIL rd_oe cyc%0d: got %b need 0", j, pad_oe); end
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_early_vld cyc%0d: got %b need 0", j, rsp_valid); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rd_ready cyc%0d: got %b need 0", j, req_ready); end
`ifdef MEMBUS_PARITY_EN
            if (j == RD_LATENCY) exp_err = (^pad_din) ^ pad_par_in;
`endif
            if (j == 1) req_valid = 1'b0;
        end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_vld: got %b need 1", rsp_valid); end
        checks++; if (rsp_rdata !== exp) begin errors++; $display("FAIL rd_data: got %h need %h", rsp_rdata, exp); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_done_ready: got %b need 1", req_ready); end
        checks++; if (pad_oe !== 1'b0) begin errors++; $display("FAIL rd_done_oe: got %b need 0", pad_oe); end
`ifdef MEMBUS_PARITY_EN
        checks++; if (rsp_par_err !== exp_err) begin errors++; $display("FAIL rd_par_err: got %b need %b", rsp_par_err, exp_err); end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h55; req_wdata = 16'h1234;
        repeat (2) @(negedge clk);
        checks++; if (pad_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b need 0", pad_oe); end
        checks++; if (pad_addr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h need 00", pad_addr); end
        checks++; if (pad_dout !== 16'h0000) begin errors++; $display("FAIL rst_dout: got %h need 0000", pad_dout); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b need 0", rsp_valid); end
        checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata: got %h need 0000", rsp_rdata); end
`ifdef MEMBUS_PARITY_EN
        checks++; if (rsp_par_err !== 1'b0) begin errors++; $display("FAIL rst_par_err: got %b need 0", rsp_par_err); end
`endif
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_rel_ready: got %b need 1", req_ready); end
        checks++; if (pad_oe !== 1'b0) begin errors++; $display("FAIL rst_no_accept: pad_oe got %b need 0", pad_oe); end
    endtask

    task automatic test_write();
        present(1'b1, 8'hA5, 16'hBEEF);
        write_phase(8'hA5, 16'hBEEF, 1'b0, '0);
    endtask

    task automatic test_read();
        preload(8'h3C, 16'h1234);
        present(1'b0, 8'h3C, '0);
        read_phase(16'h1234);
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_one_shot: got %b need 0", rsp_valid); end
        checks++; if (rsp_rdata !== 16'h1234) begin errors++; $display("FAIL rd_hold: got %h need 1234", rsp_rdata); end
    endtask

    task automatic test_write_then_read();
        present(1'b1, 8'h10, 16'h00FF);
        write_phase(8'h10, 16'h00FF, 1'b1, 8'h10);
        read_phase(16'h00FF);
    endtask

    task automatic test_reset_in_read();
        preload(8'h77, 16'hCAFE);
        present(1'b0, 8'h77, '0);
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstrd_ready: got %b need 1", req_ready); end
        checks++; if (pad_addr !== 8'h00) begin errors++; $display("FAIL rstrd_addr: got %h need 00", pad_addr); end
        for (int j = 0; j <= RD_LATENCY + 1; j++) begin
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstrd_vld cyc%0d: got %b need 0", j, rsp_valid); end
            @(negedge clk);
        end
    endtask

`ifdef MEMBUS_PARITY_EN
    task automatic test_parity();
        present(1'b1, 8'h20, 16'h0001);
        write_phase(8'h20, 16'h0001, 1'b0, '0);
        ovr_en = 1'b1; ovr_din = 16'h0003; ovr_par = 1'b1;
        present(1'b0, 8'h20, '0);
        read_phase(16'h0003);
        checks++; if (rsp_par_err !== 1'b1) begin errors++; $display("FAIL par_err_set: got %b need 1", rsp_par_err); end
        ovr_par = 1'b0;
        present(1'b0, 8'h20, '0);
        read_phase(16'h0003);
        checks++; if (rsp_par_err !== 1'b0) begin errors++; $display("FAIL par_err_clr: got %b need 0", rsp_par_err); end
        ovr_en = 1'b0;
    endtask
`endif

    // Chained random traffic over 8 addresses; each request is presented the cycle req_ready returns.
    task automatic test_back_to_back();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              we;
        for (int i = 0; i < 60; i++) begin
            a  = ADDR_W'(8'hC0 + (i < 8 ? i : $urandom_range(0, 7)));
            d  = DATA_W'($urandom);
            we = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            present(we, a, d);
            if (we) write_phase(a, d, 1'b0, '0);
            else read_phase(ref_mem[a]);
        end
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_write_then_read();
        test_reset_in_read();
`ifdef MEMBUS_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
